// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential MIPS ALU (alu_seq):
//   - 6-bit opcode encodings for logic, arithmetic, compare, shift and
//     multiply/divide operations
//   - FSM state enumeration used by the top-level control
// ---------------------------------------------------------------------------
package alu_pkg;

  // Logic / arithmetic ops keep the legacy datapath encoding.
  localparam logic [5:0] OP_AND   = 6'd0;
  localparam logic [5:0] OP_OR    = 6'd1;
  localparam logic [5:0] OP_ADD   = 6'd2;
  localparam logic [5:0] OP_SLL   = 6'd3;
  localparam logic [5:0] OP_SRL   = 6'd4;
  localparam logic [5:0] OP_SRA   = 6'd5;
  localparam logic [5:0] OP_SUB   = 6'd6;
  localparam logic [5:0] OP_NAND  = 6'd7;
  localparam logic [5:0] OP_NOR   = 6'd12;
  localparam logic [5:0] OP_XOR   = 6'd13;
  localparam logic [5:0] OP_SLT   = 6'd14;
  localparam logic [5:0] OP_SLTU  = 6'd15;

  // Iterative ops handled by the multiply/divide engine.
  localparam logic [5:0] OP_MULTU = 6'd24;
  localparam logic [5:0] OP_DIVU  = 6'd25;
  localparam logic [5:0] OP_MULT  = 6'd26;
  localparam logic [5:0] OP_DIV   = 6'd27;

  // Control FSM states.
  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if
// Issue/result bus of the sequential ALU.
//   Issue side  : in_valid, in_ready, opp_code, a, b
//   Result side : out_valid, out_ready, out, out_hi, zero, overflow
//   Status      : busy (multiply/divide iteration in progress)
// Modports:
//   master - issuing/consuming logic (decode/issue + writeback)
//   slave  - the ALU itself
// ---------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 6
);

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  opp_code;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_hi;
  logic             zero;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, opp_code, a, b, out_ready,
    input  in_ready, out_valid, out, out_hi, zero, overflow, busy
  );

  modport slave (
    input  in_valid, opp_code, a, b, out_ready,
    output in_ready, out_valid, out, out_hi, zero, overflow, busy
  );

endinterface

// File: rtl/alu_muldiv_iter.sv
// ---------------------------------------------------------------------------
// alu_muldiv_iter
// WIDTH-step iterative unsigned multiply / restoring divide engine.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands and clear the step counter
//   run        : advance one step per cycle until done
//   is_div     : 1 = divide (op_a / op_b), 0 = multiply (op_a * op_b)
//   op_a, op_b : unsigned operands (multiplier/dividend, multiplicand/divisor)
//   done       : all WIDTH steps completed
//   hi, lo     : product {hi,lo}, or remainder (hi) and quotient (lo)
// ---------------------------------------------------------------------------
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] operand_b;
  logic             mode_div;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] next_lo;

  assign done = (cnt == CNT_W'(WIDTH));

  // One iteration step. The multiplier sits in lo and shifts out LSB-first
  // while product bits shift in from the top; for division lo holds the
  // dividend shifting out MSB-first with quotient bits entering at the LSB.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, operand_b} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, operand_b});
    if (mode_div) begin
      // The restored remainder is always below the divisor, so the W-bit
      // difference is exact even when div_shift needs W+1 bits.
      next_hi = div_ge ? (div_shift[WIDTH-1:0] - operand_b) : div_shift[WIDTH-1:0];
      next_lo = {lo[WIDTH-2:0], div_ge};
    end else begin
      next_hi = mul_sum[WIDTH:1];
      next_lo = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  // Working registers and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      operand_b <= '0;
      mode_div  <= 1'b0;
    end else if (start) begin
      cnt       <= '0;
      hi        <= '0;
      lo        <= op_a;
      operand_b <= op_b;
      mode_div  <= is_div;
    end else if (run && !done) begin
      cnt <= cnt + 1'b1;
      hi  <= next_hi;
      lo  <= next_lo;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Handshaked ALU for the MIPS datapath. Single-cycle ops (logic, add/sub,
// set-less-than, shifts) return a registered result one cycle after accept;
// multiply/divide run on alu_muldiv_iter and return after WIDTH+2 cycles
// with HI/LO results.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (aborts any iteration)
//   bus   : alu_seq_if.slave - issue handshake, operands, result handshake,
//           zero/overflow flags, busy
// Optional build macro ALU_SIGNED_MULDIV_EN enables signed mult (26) and
// div (27); without it those opcodes decode as unknown (result 0).
// ---------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 6
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  localparam int SH_W = $clog2(WIDTH);

  state_t           state;
  state_t           next_state;
  logic [OP_W-1:0]  op;
  logic             in_ready;
  logic             accept;
  logic             busy;
  logic             eng_start;
  logic             eng_run;
  logic             fix_load;
  logic             is_mul;
  logic             is_div;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             dz_r;
  logic [WIDTH-1:0] a_raw;
  logic             eng_done;
  logic [WIDTH-1:0] eng_hi;
  logic [WIDTH-1:0] eng_lo;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] out_hi_r;
  logic             zero_r;
  logic             ovf_r;
  logic             out_valid_r;
`ifdef ALU_SIGNED_MULDIV_EN
  logic               is_sgn;
  logic               sgn_r;
  logic               op_div_r;
  logic               neg_q_r;
  logic               neg_r_r;
  logic [2*WIDTH-1:0] prod_neg;
`endif

  assign op      = bus.opp_code;
  assign shamt   = bus.b[SH_W-1:0];
  assign add_res = bus.a + bus.b;
  assign sub_res = bus.a - bus.b;
  assign accept  = bus.in_valid && in_ready;

  // Which opcodes go to the iterative engine.
  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
`ifdef ALU_SIGNED_MULDIV_EN
    is_sgn = 1'b0;
`endif
    case (op)
      OP_MULTU: is_mul = 1'b1;
      OP_DIVU:  is_div = 1'b1;
`ifdef ALU_SIGNED_MULDIV_EN
      OP_MULT: begin
        is_mul = 1'b1;
        is_sgn = 1'b1;
      end
      OP_DIV: begin
        is_div = 1'b1;
        is_sgn = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Single-cycle result; unknown opcodes fall through to zero.
  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (op)
      OP_AND:  sc_res = bus.a & bus.b;
      OP_OR:   sc_res = bus.a | bus.b;
      OP_NAND: sc_res = ~(bus.a & bus.b);
      OP_NOR:  sc_res = ~(bus.a | bus.b);
      OP_XOR:  sc_res = bus.a ^ bus.b;
      OP_ADD: begin
        sc_res = add_res;
        sc_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = sub_res;
        sc_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_SLL:  sc_res = bus.a << shamt;
      OP_SRL:  sc_res = bus.a >> shamt;
      OP_SRA:  sc_res = WIDTH'($signed(bus.a) >>> shamt);
      default: ;
    endcase
  end

  // Signed ops iterate on magnitudes; the sign is re-applied in FIX.
`ifdef ALU_SIGNED_MULDIV_EN
  assign mag_a = (is_sgn && bus.a[WIDTH-1]) ? (-bus.a) : bus.a;
  assign mag_b = (is_sgn && bus.b[WIDTH-1]) ? (-bus.b) : bus.b;
`else
  assign mag_a = bus.a;
  assign mag_b = bus.b;
`endif

  // Per-operation context captured when a mul/div is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dz_r  <= 1'b0;
      a_raw <= '0;
`ifdef ALU_SIGNED_MULDIV_EN
      sgn_r    <= 1'b0;
      op_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
`endif
    end else if (eng_start) begin
      dz_r  <= is_div && (bus.b == '0);
      a_raw <= bus.a;
`ifdef ALU_SIGNED_MULDIV_EN
      sgn_r    <= is_sgn;
      op_div_r <= is_div;
      neg_q_r  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      neg_r_r  <= bus.a[WIDTH-1];
`endif
    end
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (eng_start),
    .run    (eng_run),
    .is_div (is_div),
    .op_a   (mag_a),
    .op_b   (mag_b),
    .done   (eng_done),
    .hi     (eng_hi),
    .lo     (eng_lo)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // FSM next-state logic. Division by zero skips straight to FIX.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept && is_mul)      next_state = MUL;
        else if (accept && is_div) next_state = DIV;
      end
      MUL:  if (eng_done)         next_state = FIX;
      DIV:  if (dz_r || eng_done) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: if (bus.out_ready)    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs. Accept only from IDLE when the result slot is free or
  // being drained this cycle, which allows single-cycle ops at full rate.
  always_comb begin
    in_ready  = (state == IDLE) && (!out_valid_r || bus.out_ready);
    busy      = (state == MUL) || (state == DIV);
    eng_run   = busy;
    eng_start = accept && (is_mul || is_div);
    fix_load  = (state == FIX);
  end

  // Final HI/LO values, including sign correction and divide-by-zero.
  always_comb begin
    fix_lo = eng_lo;
    fix_hi = eng_hi;
`ifdef ALU_SIGNED_MULDIV_EN
    prod_neg = -{eng_hi, eng_lo};
    if (sgn_r) begin
      if (op_div_r) begin
        if (neg_q_r) fix_lo = -eng_lo;
        if (neg_r_r) fix_hi = -eng_hi;
      end else if (neg_q_r) begin
        fix_hi = prod_neg[2*WIDTH-1:WIDTH];
        fix_lo = prod_neg[WIDTH-1:0];
      end
    end
`endif
    if (dz_r) begin
      fix_lo = '1;
      fix_hi = a_raw;
    end
  end

  // Result registers. They only change on a single-cycle accept or in FIX,
  // neither of which can happen while a result is waiting, so the outputs
  // hold steady until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r       <= '0;
      out_hi_r    <= '0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (accept && !is_mul && !is_div) begin
      out_r       <= sc_res;
      out_hi_r    <= '0;
      zero_r      <= (sc_res == '0);
      ovf_r       <= sc_ovf;
      out_valid_r <= 1'b1;
    end else if (fix_load) begin
      out_r       <= fix_lo;
      out_hi_r    <= fix_hi;
      zero_r      <= (fix_lo == '0);
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy;
  assign bus.out_valid = out_valid_r;
  assign bus.out       = out_r;
  assign bus.out_hi    = out_hi_r;
  assign bus.zero      = zero_r;
  assign bus.overflow  = ovf_r;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Directed-vector bench for alu_seq (WIDTH=32). Expected values are
// hand-computed constants. Signed mul/div vectors are selected by
// ALU_SIGNED_MULDIV_EN to match the build of the design.
// ---------------------------------------------------------------------------
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [5:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   nChecks = 0;
  int   nPassed = 0;
  int   seen;
  vec_t vecs [14];

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W), .OP_W(6)) bus ();

  alu_seq #(
    .WIDTH (W),
    .OP_W  (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Count one comparison and report it when it does not match.
  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    nChecks++;
    if (observed === expected) nPassed++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Issue one op starting at a falling edge; return at the next falling
  // edge, one cycle after the accepting edge.
  task automatic applyStimulus(input logic [5:0] op, input logic [W-1:0] av,
                               input logic [W-1:0] bv);
    bus.in_valid = 1'b1;
    bus.opp_code = op;
    bus.a        = av;
    bus.b        = bv;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Issue a mul/div op, measure cycles from accept edge to out_valid and
  // check the result; the result is drained before returning.
  task automatic runLong(input string tag, input logic [5:0] op,
                         input logic [W-1:0] av, input logic [W-1:0] bv,
                         input int expCycles, input logic [W-1:0] expLo,
                         input logic [W-1:0] expHi);
    int cycles;
    bus.in_valid = 1'b1;
    bus.opp_code = op;
    bus.a        = av;
    bus.b        = bv;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checkOutput({tag, "_busy"}, W'(bus.busy), 1);
    checkOutput({tag, "_in_ready"}, W'(bus.in_ready), 0);
    cycles = 0;
    while (!bus.out_valid && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput({tag, "_latency"}, W'(cycles), W'(expCycles));
    checkOutput({tag, "_out"}, bus.out, expLo);
    checkOutput({tag, "_out_hi"}, bus.out_hi, expHi);
    checkOutput({tag, "_busy_end"}, W'(bus.busy), 0);
    checkOutput({tag, "_ovf"}, W'(bus.overflow), 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs = '{
      '{OP_AND,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0},
      '{OP_OR,   32'hFF00FF00, 32'h0F0F0F0F, 32'hFF0FFF0F, 1'b0},
      '{OP_NAND, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFFFF, 1'b0},
      '{OP_NOR,  32'hF0000000, 32'h0000000F, 32'h0FFFFFF0, 1'b0},
      '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0},
      '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0},
      '{OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0},
      '{OP_SLL,  32'h00000001, 32'h00000024, 32'h00000010, 1'b0},
      '{OP_SRL,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0},
      '{OP_SRA,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0},
      '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1},
      '{OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0},
      '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0},
      '{6'd63,   32'h00001234, 32'h00005678, 32'h00000000, 1'b0}
    };

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.opp_code  = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("rst_out_valid", W'(bus.out_valid), 0);
    checkOutput("rst_out", bus.out, 0);
    checkOutput("rst_out_hi", bus.out_hi, 0);
    checkOutput("rst_zero", W'(bus.zero), 0);
    checkOutput("rst_overflow", W'(bus.overflow), 0);
    checkOutput("rst_busy", W'(bus.busy), 0);
    checkOutput("rst_in_ready", W'(bus.in_ready), 1);

    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);

    $display("[TB] add overflow and back-to-back single-cycle ops");
    applyStimulus(OP_ADD, 32'h7FFFFFFF, 32'h00000001);
    checkOutput("add_out", bus.out, 32'h80000000);
    checkOutput("add_ovf", W'(bus.overflow), 1);
    checkOutput("add_zero", W'(bus.zero), 0);
    checkOutput("add_valid", W'(bus.out_valid), 1);
    checkOutput("add_out_hi", bus.out_hi, 0);
    checkOutput("add_in_ready", W'(bus.in_ready), 1);

    applyStimulus(OP_SUB, 32'd5, 32'd5);
    checkOutput("sub_out", bus.out, 0);
    checkOutput("sub_zero", W'(bus.zero), 1);
    checkOutput("sub_ovf", W'(bus.overflow), 0);
    checkOutput("sub_in_ready", W'(bus.in_ready), 1);

    applyStimulus(OP_XOR, 32'hF0F0F0F0, 32'h0F0F0F0F);
    checkOutput("xor_out", bus.out, 32'hFFFFFFFF);
    checkOutput("xor_zero", W'(bus.zero), 0);
    checkOutput("xor_valid", W'(bus.out_valid), 1);
    checkOutput("xor_in_ready", W'(bus.in_ready), 1);

    $display("[TB] single-cycle vector table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      checkOutput($sformatf("vec%0d_out", i), bus.out, vecs[i].res);
      checkOutput($sformatf("vec%0d_ovf", i), W'(bus.overflow), W'(vecs[i].ovf));
      checkOutput($sformatf("vec%0d_zero", i), W'(bus.zero), W'(vecs[i].res == '0));
    end

    $display("[TB] unsigned multiply / divide");
    runLong("multu", OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 34, 32'hFFFFFFFE, 32'h00000001);
    applyStimulus(6'd63, 32'h1, 32'h2);
    checkOutput("unk_after_mul_out", bus.out, 0);
    checkOutput("unk_after_mul_hi", bus.out_hi, 0);
    runLong("divu", OP_DIVU, 32'd100, 32'd7, 34, 32'd14, 32'd2);
    runLong("divu0", OP_DIVU, 32'd9, 32'd0, 2, 32'hFFFFFFFF, 32'd9);

    $display("[TB] result stall");
    bus.out_ready = 1'b0;
    applyStimulus(OP_ADD, 32'd3, 32'd4);
    checkOutput("stall_first_out", bus.out, 32'd7);
    bus.in_valid = 1'b1;
    bus.opp_code = OP_XOR;
    bus.a        = 32'd1;
    bus.b        = 32'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("stall%0d_out", i), bus.out, 32'd7);
      checkOutput($sformatf("stall%0d_valid", i), W'(bus.out_valid), 1);
      checkOutput($sformatf("stall%0d_in_ready", i), W'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_drained_valid", W'(bus.out_valid), 0);
    checkOutput("stall_drained_out", bus.out, 32'd7);

    $display("[TB] reset during divide");
    bus.in_valid = 1'b1;
    bus.opp_code = OP_DIVU;
    bus.a        = 32'd100;
    bus.b        = 32'd7;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("mid_div_busy", W'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out", bus.out, 0);
    checkOutput("abort_out_hi", bus.out_hi, 0);
    checkOutput("abort_valid", W'(bus.out_valid), 0);
    checkOutput("abort_busy", W'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy) seen++;
    end
    checkOutput("abort_no_result", W'(seen), 0);

`ifdef ALU_SIGNED_MULDIV_EN
    $display("[TB] signed multiply / divide");
    runLong("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFD, 32'hFFFFFFFF);
    runLong("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd4, 34, 32'hFFFFFFF4, 32'hFFFFFFFF);
    runLong("div_min", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 34, 32'h80000000, 32'h0);
`else
    $display("[TB] signed opcodes decode as unknown");
    applyStimulus(OP_OR, 32'd1, 32'd2);
    checkOutput("pre_div_out", bus.out, 32'd3);
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    checkOutput("div27_out", bus.out, 0);
    checkOutput("div27_valid", W'(bus.out_valid), 1);
    checkOutput("div27_busy", W'(bus.busy), 0);
    applyStimulus(OP_OR, 32'd1, 32'd2);
    applyStimulus(OP_MULT, 32'd3, 32'd4);
    checkOutput("mult26_out", bus.out, 0);
    checkOutput("mult26_out_hi", bus.out_hi, 0);
`endif

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
